// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch run-state controller. Converts debounced button
//               levels into single-cycle press events. Tracks the
//               STOPPED / RUNNING / PAUSED state and issues one-cycle
//               clear and start/pause strobes.
//               Optional feature macro: STOPWATCH_CTRL_LONG_CLEAR_EN.
//               When it is defined, a clear fires only after btn_clear has
//               been held for HOLD_TICKS tick strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int HOLD_TICKS = 4,
  parameter int CW         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_pause,
  input  logic       btn_clear,
  output logic       running,
  output logic       paused,
  output logic [1:0] state,
  output logic       clear_pulse,
  output logic       pause_evt
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   paused_q, paused_d;
  logic   clear_pulse_q, clear_pulse_d;
  logic   pause_evt_q, pause_evt_d;
  logic   pause_q, pause_d;
  logic   clear_q, clear_d;
  logic   press_pause;
  logic   press_clear;
  logic   clr_req;

  // Edge history follows the button levels; a press is a 0->1 level change
  always_comb begin
    pause_d     = btn_pause;
    clear_d     = btn_clear;
    press_pause = btn_pause & ~pause_q;
    press_clear = btn_clear & ~clear_q;
  end

`ifdef STOPWATCH_CTRL_LONG_CLEAR_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] HOLD_FULL = CW'(HOLD_TICKS);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_done_q, hold_done_d;
  // armed: the current hold began with a real rising edge, so a button
  // already held across reset release cannot fire a clear
  logic          armed_q, armed_d;

  // Hold timer: count ticks while held, fire once on reaching HOLD_TICKS
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    armed_d     = armed_q | press_clear;
    clr_req     = 1'b0;
    if (!btn_clear) begin
      hold_cnt_d  = '0;
      hold_done_d = 1'b0;
      armed_d     = 1'b0;
    end else if (armed_d && !hold_done_q && tick) begin
      if (hold_cnt_q == HOLD_LAST) begin
        clr_req     = 1'b1;
        hold_cnt_d  = HOLD_FULL;
        hold_done_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + CW'(1);
      end
    end
  end

  // Hold timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      armed_q     <= armed_d;
    end
  end
`else
  // Short press clears immediately; tick and hold configuration are unused
  logic unused_cfg;
  assign unused_cfg = tick ^ (HOLD_TICKS > 0) ^ (CW > 0);

  // Clear request is the plain clear press
  always_comb begin
    clr_req = press_clear;
  end
`endif

  // Next state and strobes; clear outranks a same-cycle start/pause press
  always_comb begin
    state_d       = state_q;
    clear_pulse_d = 1'b0;
    pause_evt_d   = 1'b0;
    case (state_q)
      ST_ILLEGAL: begin
        state_d = ST_STOPPED;
      end
      default: begin
        if (clr_req) begin
          state_d       = ST_STOPPED;
          clear_pulse_d = 1'b1;
        end else if (press_pause) begin
          pause_evt_d = 1'b1;
          state_d     = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
        end
      end
    endcase
    running_d = (state_d == ST_RUNNING);
    paused_d  = (state_d == ST_PAUSED);
  end

  // State, registered outputs and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_STOPPED;
      running_q     <= 1'b0;
      paused_q      <= 1'b0;
      clear_pulse_q <= 1'b0;
      pause_evt_q   <= 1'b0;
      pause_q       <= 1'b1;
      clear_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      paused_q      <= paused_d;
      clear_pulse_q <= clear_pulse_d;
      pause_evt_q   <= pause_evt_d;
      pause_q       <= pause_d;
      clear_q       <= clear_d;
    end
  end

  assign state       = state_q;
  assign running     = running_q;
  assign paused      = paused_q;
  assign clear_pulse = clear_pulse_q;
  assign pause_evt   = pause_evt_q;

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM directly downstream of the button debouncers. It consumes the debounced, clk-synchronous levels of the start/pause and clear buttons. It turns them into single-cycle press events and keeps the stopwatch run state. It also issues a one-cycle clear strobe to the time counter. The counter advances only while `running`=1.

Parameters:
HOLD_TICKS, 4, number of `tick` strobes `btn_clear` must be held before a clear fires (only used with STOPWATCH_CTRL_LONG_CLEAR_EN); must be >= 1.
CW, 3, width of the hold counter; must satisfy 2^CW > HOLD_TICKS.

Ports:
clk  in  1  system clock, all state updates on its rising edge
rst_n  in  1  reset, asynchronous assert, active-low
tick  in  1  one-cycle timebase strobe (e.g. 1 kHz), used only for hold timing
btn_pause  in  1  debounced start/pause button level, 1 = pressed
btn_clear  in  1  debounced clear button level, 1 = pressed
running  out  1  1 while state = RUNNING
paused  out  1  1 while state = PAUSED
state  out  2  current state: 00 STOPPED, 01 RUNNING, 10 PAUSED (11 unused)
clear_pulse  out  1  one-cycle strobe: zero the time counter
pause_evt  out  1  one-cycle strobe on each accepted start/pause press

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is asynchronous and active-low. Every register uses it.
- Reset values:
  - state = STOPPED; running = 0; paused = 0; clear_pulse = 0; pause_evt = 0; hold counter = 0; hold_done = 0.
  - Edge-history registers pause_q and clear_q reset to 1. A button already held when reset releases therefore produces no press until it is released and pressed again.
- Edge detection:
  - pause_q and clear_q are updated to the current button level every cycle.
  - press_pause = btn_pause & ~pause_q.
  - press_clear = btn_clear & ~clear_q.
- All outputs are registered. An input rise sampled at edge k shows its effect after edge k: 1-cycle latency, and the strobes are exactly 1 cycle wide.
- FSM, evaluated on press_pause (P) and the clear request (C):
  - C in any state -> STOPPED, clear_pulse = 1. C has priority over a same-cycle P; no pause_evt is issued in that case.
  - STOPPED + P -> RUNNING, pause_evt = 1.
  - RUNNING + P -> PAUSED, pause_evt = 1.
  - PAUSED + P -> RUNNING, pause_evt = 1.
  - C while already STOPPED still emits clear_pulse (idempotent zeroing).
  - Encoding 11 is illegal: recover to STOPPED on the next cycle, with no strobes.
- Holding `btn_pause` does not retoggle; one toggle per rising level.
- running and paused decode from the next state, so they change together with state.
- Without the macro, C = press_clear.
- `tick` has no effect on the FSM except through hold timing.
- Asserting rst_n = 0 mid-operation (mid-hold, mid-strobe) clears all state immediately. No strobe is emitted on reset release.

Optional Feature:
Macro STOPWATCH_CTRL_LONG_CLEAR_EN.
- Defined: a long press is required.
  - While btn_clear = 1 and hold_done = 0, the hold counter increments on each `tick`.
  - When the counter would reach HOLD_TICKS, C asserts for exactly that one cycle and hold_done is set. The counter saturates.
  - btn_clear = 0 zeroes the counter and hold_done in the same cycle, including a release on the same cycle as a tick.
  - A held button fires at most once per press.
  - press_clear is ignored.
- Undefined: C = press_clear. The hold counter and hold_done are not implemented. `tick` and HOLD_TICKS are unused, and CW is ignored.

Test Plan:
1. Hold btn_pause = 1 and btn_clear = 1 through reset release, keep them 10 cycles, then release -> state stays 00, no pause_evt, no clear_pulse.
2. From STOPPED, pulse btn_pause 3 times (each 5 cycles high, 5 low) -> state 01, 10, 01. Exactly 3 pause_evt pulses, each 1 cycle wide, 1 cycle after each rise.
3. In RUNNING, raise btn_pause and btn_clear in the same cycle (macro undefined) -> state 00, one clear_pulse, no pause_evt.
4. Macro defined, HOLD_TICKS = 4, tick every 8 cycles, state RUNNING, hold btn_clear for 60 cycles -> exactly one clear_pulse, after the 4th tick while held; state 00. A release after 3 ticks -> no clear_pulse.
5. Macro defined, hold btn_clear across 2 ticks, assert rst_n = 0 for 2 cycles, keep the button held -> all outputs 0 immediately. No clear_pulse until the button is released and held again for 4 ticks.
6. In RUNNING, hold btn_pause = 1 for 100 cycles -> single transition to PAUSED, single pause_evt.
